// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Connects the execute/writeback stages to the load/store unit.
//   master: the requester. It drives the request fields and receives the response.
//   slave : the load_store_unit. It drives req_ready and the response fields.
//   Request : req_valid, req_ready, req_write, funct3, addr, store_data, rd_in
//   Response: resp_valid, load_data, rd_out, reg_write_out, misalign
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        resp_valid;
  logic [31:0] load_data;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        misalign;

  modport master (
    output req_valid, req_write, funct3, addr, store_data, rd_in,
    input  req_ready, resp_valid, load_data, rd_out, reg_write_out, misalign
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, store_data, rd_in,
    output req_ready, resp_valid, load_data, rd_out, reg_write_out, misalign
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage RV32I load/store unit with an internal word-organised RAM.
//   It supports LB/LH/LW/LBU/LHU/SB/SH/SW. Loads return an extended value and rd for writeback.
//   Misaligned requests and illegal funct3 values finish in two cycles with misalign set.
//   Ports:
//     i_clk   : rising-edge clock
//     i_reset : synchronous active-low reset
//     bus     : slave side of load_store_unit_if (request in, response out)
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_IDLE   | ready for a request; capture and check it on accept
//   S_ACCESS | perform the RAM byte-lane write or the full-word read
//   S_RESP   | one-cycle response pulse, then return to idle
module load_store_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  load_store_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_write;
  logic [2:0]        r_funct3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [4:0]        r_rd;
  logic              r_err;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_legal;
  logic              w_aligned;
  logic              w_unused;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wlane;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

  // Address bits above the RAM range are dropped, so accesses wrap.
  assign w_unused = ^bus.addr[31:ADDR_W+2];
  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_idx    = r_addr[ADDR_W+1:2];

  always_comb begin
    w_legal = 1'b0;
    if (bus.req_write) begin
      case (bus.funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        default:                w_legal = 1'b0;
      endcase
    end else begin
      case (bus.funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for every legal opcode.
  always_comb begin
    w_aligned = 1'b1;
    case (bus.funct3[1:0])
      2'b01:   w_aligned = ~bus.addr[0];
      2'b10:   w_aligned = (bus.addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (w_legal && w_aligned) ? S_ACCESS : S_RESP;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_rd     <= 5'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_funct3 <= bus.funct3;
        r_addr   <= bus.addr[ADDR_W+1:0];
        r_wdata  <= bus.store_data;
        r_rd     <= bus.rd_in;
        r_err    <= !(w_legal && w_aligned);
      end
      if (r_state == S_ACCESS && !r_write) r_rdata <= r_mem[w_idx];
    end
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_be = 4'b0001 << r_addr[1:0];
      2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_wlane = {4{r_wdata[7:0]}};
      2'b01:   w_wlane = {2{r_wdata[15:0]}};
      default: w_wlane = r_wdata;
    endcase
  end

  // The RAM has no reset. A reset during ACCESS blocks the pending write.
  always_ff @(posedge i_clk) begin
    if (i_reset && r_state == S_ACCESS && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = r_rdata[7:0];
      2'b01:   w_byte = r_rdata[15:8];
      2'b10:   w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = r_rdata;
    endcase
  end

  always_comb begin
    bus.req_ready     = (r_state == S_IDLE);
    bus.resp_valid    = 1'b0;
    bus.load_data     = 32'h0;
    bus.rd_out        = 5'd0;
    bus.reg_write_out = 1'b0;
    bus.misalign      = 1'b0;
    if (r_state == S_RESP) begin
      bus.resp_valid = 1'b1;
      if (r_err) begin
        bus.misalign = 1'b1;
      end else if (!r_write) begin
        bus.load_data     = w_ext;
        bus.rd_out        = r_rd;
        bus.reg_write_out = (r_rd != 5'd0);
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit that consumes the registered ALU result as an effective address and performs RV32I data-memory accesses (LB/LH/LW/LBU/LHU/SB/SH/SW) against an internal word-organised RAM. For loads it returns the extracted, extended value with its destination register for writeback into the register file. A valid/ready request handshake and a single-cycle response pulse connect it to the execute and writeback stages.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words in the data RAM (power of two)
- ADDR_W, 8, log2(DEPTH_WORDS); word index = addr[ADDR_W+1:2]
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- funct3  in  3  RV32I access type
- addr  in  32  effective byte address (ALU result)
- store_data  in  32  rs2 data; low byte/half/word used per funct3
- rd_in  in  5  load destination register
- resp_valid  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, else 0
- rd_out  out  5  captured rd_in for loads, else 0
- reg_write_out  out  1  1 only for a successful load with rd_out != 0
- misalign  out  1  request was misaligned or had an illegal funct3

## Operation
- States: IDLE, ACCESS, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid && req_ready, capture req_write, funct3, addr, store_data, rd_in; evaluate legality.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. All else is illegal.
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 00; bytes are always aligned.
- Legal and aligned: IDLE -> ACCESS. Otherwise: IDLE -> RESP with error flag set; RAM untouched.
- ACCESS: store writes only the addressed byte lanes (SB lane addr[1:0], SH lane pair addr[1], SW all four); load registers the full RAM word. Then -> RESP.
- RESP: resp_valid = 1 for exactly this cycle. Then -> IDLE.
- Load extraction: byte/half select by addr[1:0]/addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- In RESP:
  - Successful load: load_data = extracted value, rd_out = captured rd, reg_write_out = (rd != 0), misalign = 0.
  - Store: load_data = 0, rd_out = 0, reg_write_out = 0, misalign = 0.
  - Error: load_data = 0, rd_out = 0, reg_write_out = 0, misalign = 1.
- Outside RESP: resp_valid, reg_write_out and misalign are 0; load_data and rd_out are 0.
- req_valid in non-IDLE states is ignored; the requester holds the request until req_ready.
- RAM contents are not cleared by reset and are undefined until written.

## Timing
- Reset (reset = 0 at an edge): state -> IDLE; all captured fields cleared; outputs after that edge are req_ready = 1, all others 0. Reset has priority over every transition.
- Reset arriving while in ACCESS suppresses the pending store write; an in-flight load yields no response.
- Legal request accepted at edge N: RAM write (store) or RAM read (load) occurs at edge N+1; resp_valid is high between edges N+1 and N+2; req_ready is high again after edge N+2.
- Error request accepted at edge N: resp_valid and misalign are high between N and N+1; req_ready returns after N+1.
- Throughput is one legal access per 3 cycles and one error per 2 cycles.
- Read-after-write: a load accepted after a store's RESP cycle observes the stored data.
- All outputs are decoded from registered state and captured fields; there is no combinational path from request inputs to any output.

## Test plan
- Reset then SW addr 0x10, data 0xDEADBEEF -> resp_valid pulse 2 cycles after accept, reg_write_out = 0. LW 0x10, rd 5 -> load_data 0xDEADBEEF, rd_out 5, reg_write_out 1.
- SB 0x13 data 0x80 over word 0x00000000; then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
- SH 0x22 data 0x8001; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LH 0x21 -> misalign 1 one cycle after accept, load_data 0, RAM unchanged.
- funct3 011 load and funct3 100 store -> misalign 1, no RAM write; LW rd 0 -> reg_write_out 0.
- Wrap: SW addr 0x400 (DEPTH_WORDS 256) data 0x12345678; LW 0x000 -> 0x12345678.
- Assert reset = 0 during the ACCESS cycle of SW 0x30 data 0xFFFFFFFF over prior 0x0 -> no resp_valid; subsequent LW 0x30 -> 0x00000000; req_ready is 1 immediately after the reset edge.
